intr_ctrl: RTL and testbench
============================

# intr_ctrl

Vectored interrupt controller placed directly upstream of the single-cycle CPU's interrupt port. It collects up to N asynchronous device request lines and synchronises and edge-detects them. It applies a software mask, selects the highest-priority unmasked pending source, and drives the CPU's `intr` input. It completes a request/acknowledge/end-of-interrupt handshake with the CPU's `inta` output and a CPU-issued EOI strobe.

## Interface
- `N`, 8: number of request sources.
- `VW`, 3: vector width, equals clog2(N).
- `clk`  in  1  system clock; all state updates on rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `irq`  in  N  raw device requests, asynchronous to `clk`, rising-edge triggered.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  N  new mask value; bit=1 masks the source.
- `inta`  in  1  acknowledge from CPU.
- `eoi`  in  1  end-of-interrupt strobe from CPU.
- `intr`  out  1  interrupt request to CPU.
- `vector`  out  VW  index of the source being requested/serviced.
- `in_service`  out  1  high while the CPU is servicing a granted source.
- `pending`  out  N  latched request bits.
- `mask`  out  N  current mask register.

## Operation
- Reset (`clrn`=0): `intr`=0, `vector`=0, `in_service`=0, `pending`=0, `mask`=0 (all enabled), synchroniser flops=0, state=IDLE.
- Per source: 2-flop synchroniser s1→s2, history flop s3; edge = s2 & ~s3. An edge sets `pending[i]`.
- `mask_we`: `mask` ← `mask_wdata` on the same edge. Masking never clears `pending`. A masked source is held until unmasked.
- Priority: lowest index wins among `pending & ~mask`.
- States:
  - IDLE: `intr`=0. If any unmasked pending bit is set, latch the winner into `vector` and go to REQ.
  - REQ: `intr`=1. When `inta`=1 is sampled, clear `pending[vector]` and go to SERVICE. A mask write in REQ does not withdraw the request.
  - SERVICE: `intr`=0, `in_service`=1, `vector` held. When `eoi`=1 is sampled, go to IDLE.
- No nesting: new requests only accumulate in `pending` during REQ or SERVICE.
- Edge on `vector`'s source in the same cycle as the `inta` clear: the set wins and `pending` stays 1, giving a second request later.
- `inta` outside REQ and `eoi` outside SERVICE are ignored.

## Timing
- `irq[i]` rising before clk edge E0 gives: s1 at E0, edge detected after E1, `pending[i]`=1 after E2, state REQ and `intr`=1 after E3. The minimum request latency is 4 edges.
- `intr` falls on the edge that samples `inta`. `in_service` rises on the same edge.
- `vector` is stable from REQ entry until the edge that samples `eoi`.
- After EOI, IDLE lasts at least 1 cycle, so `intr` has a minimum 1-cycle low gap between consecutive requests.
- `irq` pulses shorter than one clk period may be lost. Devices hold `irq` for at least 2 cycles.
- Asynchronous reset mid-handshake drops `intr` immediately and discards all pending requests.

## Structure
- Package `intr_pkg`: state typedef (IDLE, REQ, SERVICE), default `N`/`VW` constants.
- Sub-module `intr_sync_edge`: one-bit 2-flop synchroniser plus edge detector, instantiated N times via generate.
- Top: pending/mask registers, priority encoder function, FSM.

## Test plan
- Reset: hold `clrn`=0 with `irq`=8'hFF → all outputs 0. Release → `intr` asserts 4 edges after `irq` first sampled, with `vector`=0.
- Single request: pulse `irq[5]` for 3 cycles, answer `inta` 2 cycles after `intr` → `intr` drops the next edge, `in_service`=1, `vector`=5, `pending`=0. `eoi` → IDLE.
- Priority: `irq[6]` and `irq[2]` together → first grant has `vector`=2. After EOI, `vector`=6 is granted with no re-pulse.
- Mask: write `mask`=8'h04, pulse `irq[2]` → no `intr`, `pending[2]`=1. Write `mask`=0 → `intr` rises 1 edge later with `vector`=2.
- Collision: re-pulse `irq[3]` so its edge coincides with the `inta` cycle for `vector`=3 → after EOI, a second request with `vector`=3 is issued.
- Stray strobes: `inta` in IDLE and `eoi` in REQ → no state change. Async `clrn` low in SERVICE → `in_service`=0 immediately.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and default sizing for the vectored interrupt controller.
package intr_pkg;

    localparam int N_DEF  = 8;
    localparam int VW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Device/CPU-facing signal bundle of the interrupt controller.
interface intr_ctrl_if #(
    parameter int N  = intr_pkg::N_DEF,
    parameter int VW = intr_pkg::VW_DEF
) ();

    logic [N-1:0]  irq;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          inta;
    logic          eoi;
    logic          intr;
    logic [VW-1:0] vector;
    logic          in_service;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;

    // Controller side
    modport slave (
        input  irq, mask_we, mask_wdata, inta, eoi,
        output intr, vector, in_service, pending, mask
    );

    // CPU / device side
    modport master (
        output irq, mask_we, mask_wdata, inta, eoi,
        input  intr, vector, in_service, pending, mask
    );

endinterface

// File: rtl/intr_sync_edge.sv
// One request line: two-flop synchroniser, history flop and rising-edge detect.
module intr_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic i_irq,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_irq;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: latches edge-triggered requests, masks them and
// runs the intr/inta/eoi handshake with the CPU, one source at a time.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int VW = VW_DEF
) (
    input  logic         clk,
    input  logic         clrn,
    intr_ctrl_if.slave   bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [VW-1:0] r_vector;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  r_mask;
    logic [N-1:0]  w_edge;
    logic [N-1:0]  w_ready;
    logic [N-1:0]  w_clr;
    logic [VW-1:0] w_winner;
    logic          w_grant;
    logic          w_ack;

    function automatic logic [VW-1:0] f_lowest(input logic [N-1:0] req);
        logic [VW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = VW'(i);
        end
        return idx;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_src
        intr_sync_edge u_sync_edge (
            .clk    (clk),
            .clrn   (clrn),
            .i_irq  (bus.irq[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_ready  = r_pending & ~r_mask;
    assign w_winner = f_lowest(w_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_ready) begin
                    w_grant     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.inta) begin
                    w_ack       = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.eoi) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A fresh edge on the acknowledged source wins over the clear, so it re-requests later
    assign w_clr = w_ack ? ({{(N-1){1'b0}}, 1'b1} << r_vector) : '0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_vector  <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (w_grant)     r_vector <= w_winner;
            if (bus.mask_we) r_mask   <= bus.mask_wdata;
        end
    end

    assign bus.intr       = (r_state == REQ);
    assign bus.in_service = (r_state == SERVICE);
    assign bus.vector     = r_vector;
    assign bus.pending    = r_pending;
    assign bus.mask       = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed handshake scenarios plus random traffic
// compared each cycle against a behavioural model of the controller.
module tb_intr_ctrl;

    logic clk;
    logic clrn;

    intr_ctrl_if #(.N(8), .VW(3)) bus ();

    intr_ctrl #(.N(8), .VW(3)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Behavioural model: history of irq samples, pending/mask words, handshake phase
    logic [7:0] hist[$];
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [2:0] m_vec;
    bit         m_req;
    bit         m_svc;
    logic [7:0] tb_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = '{8'h00, 8'h00, 8'h00};
        m_pend = '0;
        m_mask = '0;
        m_vec  = '0;
        m_req  = 0;
        m_svc  = 0;
    endtask

    // Applied at each rising edge using the inputs that were stable across it
    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] clr;
        logic [7:0] ready;
        rise  = hist[1] & ~hist[2];
        clr   = '0;
        ready = m_pend & ~m_mask;
        if (m_req) begin
            if (bus.inta) begin
                clr   = 8'(1) << m_vec;
                m_req = 0;
                m_svc = 1;
            end
        end else if (m_svc) begin
            if (bus.eoi) m_svc = 0;
        end else if (ready != 0) begin
            for (int i = 7; i >= 0; i--) if (ready[i]) m_vec = 3'(i);
            m_req = 1;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (bus.mask_we) m_mask = bus.mask_wdata;
        hist.push_front(tb_irq);
        void'(hist.pop_back());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".intr"},    32'(bus.intr),       32'(m_req));
        chk({tag, ".insvc"},   32'(bus.in_service), 32'(m_svc));
        chk({tag, ".vector"},  32'(bus.vector),     32'(m_vec));
        chk({tag, ".pending"}, 32'(bus.pending),    32'(m_pend));
        chk({tag, ".mask"},    32'(bus.mask),       32'(m_mask));
    endtask

    // Called at a negedge; drives inputs, runs one clock and checks at the next negedge
    task automatic step(input logic we, input logic [7:0] wd, input logic ia, input logic eo);
        bus.irq        = tb_irq;
        bus.mask_we    = we;
        bus.mask_wdata = wd;
        bus.inta       = ia;
        bus.eoi        = eo;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_intr(input string tag);
        for (int i = 0; i < 30 && !bus.intr; i++) idle(1);
        chk({tag, ".intr_seen"}, 32'(bus.intr), 32'd1);
    endtask

    task automatic serve(input string tag);
        wait_intr(tag);
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic pulse(input logic [7:0] bits);
        tb_irq = bits;
        idle(3);
        tb_irq = 8'h00;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        tb_irq = 8'hFF;
        bus.irq = 8'hFF;
        bus.mask_we = 0;
        bus.mask_wdata = 0;
        bus.inta = 0;
        bus.eoi = 0;
        model_reset();
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.intr", 32'(bus.intr), 32'd0);
        chk("rst.vector", 32'(bus.vector), 32'd0);
        chk("rst.insvc", 32'(bus.in_service), 32'd0);
        chk("rst.pending", 32'(bus.pending), 32'd0);
        chk("rst.mask", 32'(bus.mask), 32'd0);
        clrn = 1'b1;

        // Latency: irq already high, intr after the fourth sampling edge
        idle(3);
        chk("lat.intr_early", 32'(bus.intr), 32'd0);
        idle(1);
        chk("lat.intr", 32'(bus.intr), 32'd1);
        chk("lat.vector", 32'(bus.vector), 32'd0);
        tb_irq = 8'h00;
        for (int k = 0; k < 8; k++) serve("drain");
        idle(3);

        // Single request
        pulse(8'h20);
        wait_intr("single");
        chk("single.vector", 32'(bus.vector), 32'd5);
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single.intr_drop", 32'(bus.intr), 32'd0);
        chk("single.insvc", 32'(bus.in_service), 32'd1);
        chk("single.vec_hold", 32'(bus.vector), 32'd5);
        chk("single.pending", 32'(bus.pending), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("single.idle", 32'(bus.in_service), 32'd0);

        // Priority
        pulse(8'h44);
        wait_intr("prio1");
        chk("prio.first", 32'(bus.vector), 32'd2);
        serve("prio1");
        wait_intr("prio2");
        chk("prio.second", 32'(bus.vector), 32'd6);
        serve("prio2");
        idle(2);

        // Mask holds a source without discarding it
        step(1'b1, 8'h04, 1'b0, 1'b0);
        pulse(8'h04);
        idle(6);
        chk("mask.no_intr", 32'(bus.intr), 32'd0);
        chk("mask.pend2", 32'(bus.pending[2]), 32'd1);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        idle(1);
        chk("mask.intr", 32'(bus.intr), 32'd1);
        chk("mask.vector", 32'(bus.vector), 32'd2);
        serve("mask");
        idle(2);

        // Collision: re-raised irq[3] reaches the edge detector on the inta edge
        pulse(8'h08);
        wait_intr("coll");
        chk("coll.vector", 32'(bus.vector), 32'd3);
        tb_irq = 8'h08;
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("coll.pend3", 32'(bus.pending[3]), 32'd1);
        tb_irq = 8'h00;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        wait_intr("coll2");
        chk("coll.again", 32'(bus.vector), 32'd3);
        serve("coll2");
        idle(2);

        // Stray strobes, then async reset during service
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stray.inta", 32'(bus.intr | bus.in_service), 32'd0);
        pulse(8'h01);
        wait_intr("stray");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stray.eoi", 32'(bus.intr), 32'd1);
        tb_irq = 8'h80;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("areset.before", 32'(bus.in_service), 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("areset.insvc", 32'(bus.in_service), 32'd0);
        chk("areset.intr", 32'(bus.intr), 32'd0);
        chk("areset.pending", 32'(bus.pending), 32'd0);
        model_reset();
        tb_irq = 8'h00;
        @(negedge clk);
        clrn = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic       we;
            logic [7:0] wd;
            if ((c % 2) == 0 && $urandom_range(0, 2) == 0)
                tb_irq = tb_irq ^ (8'($urandom) & 8'($urandom));
            we = ($urandom_range(0, 15) == 0);
            wd = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(we, wd, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
